// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receiver: FSM state and frame error encoding.
package ps2_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DATA   = 2'b01,
      ST_PARITY = 2'b10,
      ST_STOP   = 2'b11
   } ps2_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_PARITY  = 2'b01,
      ERR_STOP    = 2'b10,
      ERR_TIMEOUT = 2'b11
   } ps2_err_e;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus glitch filter for one raw PS/2 line; idles high.
module ps2_line_filter #(
   parameter int FILTER_CYCLES = 19
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic line_o
);

   localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter resets on every switch, so it never exceeds CNT_LAST.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= line_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign line_o = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with parity/stop/timeout checking.
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a clock falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | next falling edge ends the frame and it is evaluated
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_CYCLES  = 19,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       hold,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err,
   output logic [1:0] err_kind,
   output logic       busy
);

   localparam int BW = $clog2(DATA_BITS);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic clk_f, data_f, clk_prev_q, fall;

   ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
      .clk(clk), .rst(rst), .line_i(ps2_clk), .line_o(clk_f)
   );

   ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
      .clk(clk), .rst(rst), .line_i(ps2_data), .line_o(data_f)
   );

   assign fall = clk_prev_q & ~clk_f;

   ps2_state_e          state_q, state_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                parity_q, parity_d;
   logic [7:0]          code_q, code_d;
   logic                code_valid_q, code_valid_d;
   logic                frame_err_q, frame_err_d;
   ps2_err_e            err_kind_q, err_kind_d;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      err_kind_d   = ERR_NONE;
      if (hold) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         tmo_cnt_d = '0;
      end else begin
         if (state_q == ST_IDLE || fall) begin
            tmo_cnt_d = '0;
         end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (fall && !data_f) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               if (fall) begin
                  shift_d = {data_f, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = ST_PARITY;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (fall) begin
                  parity_d = data_f;
                  state_d  = ST_STOP;
               end
            end
            ST_STOP: begin
               if (fall) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
                  // A bad stop bit outranks a parity error.
                  if (!data_f) begin
                     frame_err_d = 1'b1;
                     err_kind_d  = ERR_STOP;
                  end else if (!(^{shift_q, parity_q})) begin
                     frame_err_d = 1'b1;
                     err_kind_d  = ERR_PARITY;
                  end else begin
                     code_d       = shift_q;
                     code_valid_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (state_q != ST_IDLE && !fall && tmo_cnt_q == TMO_LAST) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            tmo_cnt_d   = '0;
            frame_err_d = 1'b1;
            err_kind_d  = ERR_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_prev_q   <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         code_q       <= 8'h00;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_kind_q   <= ERR_NONE;
      end else begin
         clk_prev_q   <= clk_f;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
         err_kind_q   <= err_kind_d;
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;
   assign err_kind   = err_kind_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: good/bad frames, timeout, glitch, hold, reset.
module tb_ps2_receiver;

   localparam int FILT = 19;
   localparam int TMO  = 1000;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       hold = 1'b0;
   logic [7:0] code;
   logic       code_valid, frame_err, busy;
   logic [1:0] err_kind;

   int checks = 0;
   int failures = 0;
   int cv_cnt = 0;
   int fe_cnt = 0;
   int excl_viol = 0;
   logic [1:0] last_kind = 2'b00;
   int lat = 0;

   ps2_receiver #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .hold(hold),
      .code(code), .code_valid(code_valid), .frame_err(frame_err),
      .err_kind(err_kind), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (code_valid) cv_cnt = cv_cnt + 1;
      if (frame_err) begin
         fe_cnt = fe_cnt + 1;
         last_kind = err_kind;
      end
      if (code_valid && frame_err) excl_viol = excl_viol + 1;
      if (!frame_err && err_kind != 2'b00) excl_viol = excl_viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One PS/2 bit; records cycles from the clock drop to the first output pulse.
   task automatic send_bit(input logic b);
      ps2_data = b;
      cycles(HALF);
      ps2_clk = 1'b0;
      lat = 0;
      for (int i = 1; i <= HALF; i++) begin
         @(posedge clk);
         #1;
         if ((code_valid || frame_err) && lat == 0) lat = i;
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      send_bit(1'b0);
      for (int i = 0; i < n; i++) send_bit(d[i]);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      send_bits(d, 8);
      send_bit(par);
      send_bit(stp);
      ps2_data = 1'b1;
      cycles(2 * HALF);
   endtask

   int cv0, fe0, waited;

   initial begin
      cycles(5);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_code", 32'(code), 32'h00);
      chk("rst_cv", 32'(code_valid), 0);
      chk("rst_fe", 32'(frame_err), 0);
      chk("rst_kind", 32'(err_kind), 0);
      chk("rst_busy", 32'(busy), 0);
      cycles(30);

      // 0x1C has three ones, so odd parity bit is 0
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      chk("good_code", 32'(code), 32'h1C);
      chk("good_cv_cnt", 32'(cv_cnt - cv0), 1);
      chk("good_fe_cnt", 32'(fe_cnt - fe0), 0);
      chk("good_busy", 32'(busy), 0);

      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, 1'b1, 1'b1);
      chk("lat_err", 32'(lat), 22);
      chk("par_fe_cnt", 32'(fe_cnt - fe0), 1);
      chk("par_kind", 32'(last_kind), 2'b01);
      chk("par_code_kept", 32'(code), 32'h1C);
      chk("par_cv_cnt", 32'(cv_cnt - cv0), 0);

      // 0xF0 correct parity is 1; send 0 and a bad stop bit
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'hF0, 1'b0, 1'b0);
      chk("stop_fe_cnt", 32'(fe_cnt - fe0), 1);
      chk("stop_kind", 32'(last_kind), 2'b10);
      chk("stop_code_kept", 32'(code), 32'h1C);

      fe0 = fe_cnt; cv0 = cv_cnt;
      send_bits(8'hA5, 4);
      cycles(5);
      chk("tmo_busy_mid", 32'(busy), 1);
      waited = 0;
      while (fe_cnt == fe0 && waited < TMO + 300) begin
         cycles(1);
         waited++;
      end
      chk("tmo_seen", 32'(waited < TMO + 300), 1);
      chk("tmo_kind", 32'(last_kind), 2'b11);
      chk("tmo_busy", 32'(busy), 0);
      cycles(5);
      // 0x12 has two ones, so parity bit is 1
      send_frame(8'h12, 1'b1, 1'b1);
      chk("lat_good", 32'(lat), 22);
      chk("tmo_next_code", 32'(code), 32'h12);
      chk("tmo_next_cv", 32'(cv_cnt - cv0), 1);

      // Clock glitches with data low: one cycle short of the filter is ignored.
      cv0 = cv_cnt; fe0 = fe_cnt;
      ps2_data = 1'b0;
      cycles(3 * FILT);
      ps2_clk = 1'b0;
      cycles(FILT - 1);
      ps2_clk = 1'b1;
      cycles(3 * FILT);
      chk("glitch_short_busy", 32'(busy), 0);
      chk("glitch_short_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 0);
      ps2_clk = 1'b0;
      cycles(FILT);
      ps2_clk = 1'b1;
      cycles(3 * FILT);
      chk("glitch_full_busy", 32'(busy), 1);
      ps2_data = 1'b1;
      cycles(TMO + 100);
      chk("glitch_full_tmo", 32'(fe_cnt - fe0), 1);
      chk("glitch_full_idle", 32'(busy), 0);

      // 0x5A has four ones, so parity bit is 1
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_bits(8'h5A, 3);
      hold = 1'b1;
      cycles(3);
      chk("hold_busy", 32'(busy), 0);
      for (int i = 3; i < 8; i++) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      cycles(2 * HALF);
      chk("hold_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 0);
      hold = 1'b0;
      cycles(10);
      send_frame(8'h5A, 1'b1, 1'b1);
      chk("hold_next_code", 32'(code), 32'h5A);
      chk("hold_next_cv", 32'(cv_cnt - cv0), 1);
      chk("hold_next_fe", 32'(fe_cnt - fe0), 0);

      cv0 = cv_cnt; fe0 = fe_cnt;
      send_bits(8'h77, 5);
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(3 * HALF);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_code", 32'(code), 32'h00);
      chk("midrst_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 0);

      chk("exclusive_outputs", 32'(excl_viol), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
